// File: rtl/vid_scan_gen.sv
// Raster timing generator and RGB555 pixel pacer for the DVI/TMDS output stage.
// Pulls pixels over valid/ready during active video and emits registered colour/blanking.
module vid_scan_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_BLANK  = 160,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_BLANK  = 45,
   parameter logic [14:0] UF_COLOR = 15'h7C1F
) (
   input  logic        VID_CLK,
   input  logic        VID_RST_N,
   input  logic        EN,
   input  logic [14:0] PIX_DATA,
   input  logic        PIX_VALID,
   output logic        PIX_READY,
   output logic        FRAME_START,
   output logic        LINE_START,
   input  logic        UF_CLR,
   output logic        UNDERFLOW,
   output logic [4:0]  VID_R,
   output logic [4:0]  VID_G,
   output logic [4:0]  VID_B,
   output logic        VID_HS,
   output logic        VID_VS
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_BLANK;
   localparam int unsigned HW      = $clog2(H_TOTAL);
   localparam int unsigned VW      = $clog2(V_TOTAL);
   localparam int unsigned PW      = 15;

   logic [HW-1:0] hc, hc_nxt;
   logic [VW-1:0] vc, vc_nxt;
   logic [PW-1:0] rgb_q, rgb_nxt;
   logic          hs_q, hs_nxt;
   logic          vs_q, vs_nxt;
   logic          uf_q, uf_nxt;

   logic h_act, v_act, act, h_last, v_last, xfer, starve;

   // Raster position decode
   always_comb begin
      h_act  = hc < HW'(H_ACTIVE);
      v_act  = vc < VW'(V_ACTIVE);
      h_last = hc == HW'(H_TOTAL - 1);
      v_last = vc == VW'(V_TOTAL - 1);
      act    = EN & h_act & v_act;
      xfer   = act & PIX_VALID;
      starve = act & ~PIX_VALID;
   end

   // Handshake and sync pulses are combinational; forced low while reset is held
   always_comb begin
      PIX_READY   = VID_RST_N & act;
      FRAME_START = VID_RST_N & EN & (hc == '0) & (vc == '0);
      LINE_START  = VID_RST_N & EN & (hc == '0) & v_act;
   end

   // Next-state: counters and the one-stage output pipeline
   always_comb begin
      hc_nxt  = '0;
      vc_nxt  = vc;
      rgb_nxt = '0;
      hs_nxt  = 1'b1;
      vs_nxt  = 1'b1;
      uf_nxt  = uf_q;

      if (!EN) begin
         vc_nxt = '0;
      end else if (h_last) begin
         vc_nxt = v_last ? '0 : vc + VW'(1);
      end else begin
         hc_nxt = hc + HW'(1);
      end

      if (xfer) begin
         rgb_nxt = PIX_DATA;
      end else if (starve) begin
         rgb_nxt = UF_COLOR;
      end

      hs_nxt = ~EN | ~h_act;
      vs_nxt = ~EN | ~v_act;

      // A starved pixel outranks a simultaneous clear
      if (starve) begin
         uf_nxt = 1'b1;
      end else if (UF_CLR) begin
         uf_nxt = 1'b0;
      end
   end

   always_ff @(posedge VID_CLK) begin
      if (!VID_RST_N) begin
         hc    <= '0;
         vc    <= '0;
         rgb_q <= '0;
         hs_q  <= 1'b1;
         vs_q  <= 1'b1;
         uf_q  <= 1'b0;
      end else begin
         hc    <= hc_nxt;
         vc    <= vc_nxt;
         rgb_q <= rgb_nxt;
         hs_q  <= hs_nxt;
         vs_q  <= vs_nxt;
         uf_q  <= uf_nxt;
      end
   end

   always_comb begin
      VID_R     = rgb_q[14:10];
      VID_G     = rgb_q[9:5];
      VID_B     = rgb_q[4:0];
      VID_HS    = hs_q;
      VID_VS    = vs_q;
      UNDERFLOW = uf_q;
   end

endmodule

// File: tb/tb_vid_scan_gen.sv
// Bench for vid_scan_gen on a tiny 6x5 raster: frame-position model plus directed literal checks.
module tb_vid_scan_gen;

   localparam int HA = 4;
   localparam int HB = 2;
   localparam int VA = 3;
   localparam int VB = 2;
   localparam int HT = HA + HB;
   localparam int FT = HT * (VA + VB);
   localparam logic [14:0] UF = 15'h7C1F;

   logic        VID_CLK = 1'b0;
   logic        VID_RST_N;
   logic        EN;
   logic [14:0] PIX_DATA;
   logic        PIX_VALID;
   logic        PIX_READY;
   logic        FRAME_START;
   logic        LINE_START;
   logic        UF_CLR;
   logic        UNDERFLOW;
   logic [4:0]  VID_R, VID_G, VID_B;
   logic        VID_HS, VID_VS;

   vid_scan_gen #(
      .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .UF_COLOR(UF)
   ) dut (
      .VID_CLK(VID_CLK), .VID_RST_N(VID_RST_N), .EN(EN),
      .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
      .FRAME_START(FRAME_START), .LINE_START(LINE_START),
      .UF_CLR(UF_CLR), .UNDERFLOW(UNDERFLOW),
      .VID_R(VID_R), .VID_G(VID_G), .VID_B(VID_B),
      .VID_HS(VID_HS), .VID_VS(VID_VS)
   );

   always #5 VID_CLK = ~VID_CLK;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, got, exp);
      end
   endtask

   // Model: the raster is a single position index 0..FT-1 within the frame
   int          m_pos   = 0;
   int          src_cnt = 1;
   logic [14:0] e_rgb;
   logic        e_hs, e_vs, e_uf;
   bit          chk_en  = 1'b0;

   function automatic bit in_act(input int p);
      return ((p % HT) < HA) && ((p / HT) < VA);
   endfunction

   always @(posedge VID_CLK) begin
      if (!VID_RST_N) begin
         e_rgb  <= '0;
         e_hs   <= 1'b1;
         e_vs   <= 1'b1;
         e_uf   <= 1'b0;
         m_pos  <= 0;
         chk_en <= 1'b1;
      end else begin
         if (EN && in_act(m_pos)) begin
            if (PIX_VALID) begin
               e_rgb   <= PIX_DATA;
               src_cnt <= src_cnt + 1;
               if (UF_CLR) e_uf <= 1'b0;
            end else begin
               e_rgb <= UF;
               e_uf  <= 1'b1;
            end
         end else begin
            e_rgb <= '0;
            if (UF_CLR) e_uf <= 1'b0;
         end
         e_hs  <= !EN || ((m_pos % HT) >= HA);
         e_vs  <= !EN || ((m_pos / HT) >= VA);
         m_pos <= EN ? (m_pos + 1) % FT : 0;
      end
   end

   always @(negedge VID_CLK) begin
      if (chk_en) begin
         chk("rgb", 32'({VID_R, VID_G, VID_B}), 32'(e_rgb));
         chk("hs", 32'(VID_HS), 32'(e_hs));
         chk("vs", 32'(VID_VS), 32'(e_vs));
         chk("underflow", 32'(UNDERFLOW), 32'(e_uf));
         chk("ready", 32'(PIX_READY), 32'(VID_RST_N && EN && in_act(m_pos)));
         chk("frame_start", 32'(FRAME_START), 32'(VID_RST_N && EN && m_pos == 0));
         chk("line_start", 32'(LINE_START),
             32'(VID_RST_N && EN && (m_pos % HT) == 0 && (m_pos / HT) < VA));
      end
   end

   task automatic step();
      @(posedge VID_CLK);
      #2;
      PIX_DATA = 15'(src_cnt);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end

   logic [4:0] lit_b [6];
   logic       lit_hs[6];

   initial begin
      lit_b  = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd0, 5'd0};
      lit_hs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      VID_RST_N = 1'b0;
      EN        = 1'b0;
      PIX_VALID = 1'b0;
      PIX_DATA  = '0;
      UF_CLR    = 1'b0;
      repeat (2) step();
      @(negedge VID_CLK);
      chk("lit_rst_hs", 32'(VID_HS), 32'd1);
      chk("lit_rst_rgb", 32'({VID_R, VID_G, VID_B}), 32'd0);
      chk("lit_rst_ready", 32'(PIX_READY), 32'd0);

      // First frame: always-valid incrementing source
      step();
      VID_RST_N = 1'b1;
      EN        = 1'b1;
      PIX_VALID = 1'b1;
      @(negedge VID_CLK);
      chk("lit_fs0", 32'(FRAME_START), 32'd1);
      for (int i = 0; i < 6; i++) begin
         step();
         @(negedge VID_CLK);
         chk("lit_line0_b", 32'(VID_B), 32'(lit_b[i]));
         chk("lit_line0_hs", 32'(VID_HS), 32'(lit_hs[i]));
      end
      for (int c = 7; c <= 30; c++) begin
         step();
         @(negedge VID_CLK);
         if (c == 18) chk("lit_vs_line2", 32'(VID_VS), 32'd0);
         if (c == 19) chk("lit_vs_line3", 32'(VID_VS), 32'd1);
         if (c == 29) chk("lit_fs29", 32'(FRAME_START), 32'd0);
         if (c == 30) chk("lit_fs30", 32'(FRAME_START), 32'd1);
      end

      // Starve pixel hc=2,vc=1 of frame 2
      repeat (8) step();
      PIX_VALID = 1'b0;
      step();
      PIX_VALID = 1'b1;
      @(negedge VID_CLK);
      chk("lit_uf_rgb", 32'({VID_R, VID_G, VID_B}), 32'(UF));
      chk("lit_uf_flag", 32'(UNDERFLOW), 32'd1);
      step();
      UF_CLR = 1'b1;
      @(negedge VID_CLK);
      chk("lit_resume_b", 32'(VID_B), 32'd19);
      chk("lit_uf_held", 32'(UNDERFLOW), 32'd1);
      step();
      UF_CLR = 1'b0;
      @(negedge VID_CLK);
      chk("lit_uf_cleared", 32'(UNDERFLOW), 32'd0);

      // Clear coinciding with a starved pixel
      step();
      PIX_VALID = 1'b0;
      UF_CLR    = 1'b1;
      step();
      PIX_VALID = 1'b1;
      UF_CLR    = 1'b0;
      @(negedge VID_CLK);
      chk("lit_set_wins", 32'(UNDERFLOW), 32'd1);
      step();
      UF_CLR = 1'b1;
      step();
      UF_CLR = 1'b0;
      @(negedge VID_CLK);
      chk("lit_uf_cleared2", 32'(UNDERFLOW), 32'd0);

      // Valid source during horizontal blanking
      step();
      @(negedge VID_CLK);
      chk("lit_blank_ready", 32'(PIX_READY), 32'd0);
      step();
      @(negedge VID_CLK);
      chk("lit_blank_rgb", 32'({VID_R, VID_G, VID_B}), 32'd0);

      // Disable at hc=1,vc=2 of frame 3, then re-enable
      repeat (26) step();
      EN = 1'b0;
      @(negedge VID_CLK);
      chk("lit_dis_ready", 32'(PIX_READY), 32'd0);
      step();
      @(negedge VID_CLK);
      chk("lit_dis_hs", 32'(VID_HS), 32'd1);
      chk("lit_dis_vs", 32'(VID_VS), 32'd1);
      chk("lit_dis_rgb", 32'({VID_R, VID_G, VID_B}), 32'd0);
      repeat (3) step();
      EN = 1'b1;
      @(negedge VID_CLK);
      chk("lit_reen_fs", 32'(FRAME_START), 32'd1);
      step();
      @(negedge VID_CLK);
      chk("lit_reen_pix", 32'({VID_R, VID_G, VID_B}), 32'd32);

      // Underflow then a one-cycle reset mid-line
      PIX_VALID = 1'b0;
      step();
      PIX_VALID = 1'b1;
      VID_RST_N = 1'b0;
      @(negedge VID_CLK);
      chk("lit_pre_rst_uf", 32'(UNDERFLOW), 32'd1);
      chk("lit_rst_ready_low", 32'(PIX_READY), 32'd0);
      step();
      VID_RST_N = 1'b1;
      @(negedge VID_CLK);
      chk("lit_mrst_hs", 32'(VID_HS), 32'd1);
      chk("lit_mrst_vs", 32'(VID_VS), 32'd1);
      chk("lit_mrst_rgb", 32'({VID_R, VID_G, VID_B}), 32'd0);
      chk("lit_mrst_uf", 32'(UNDERFLOW), 32'd0);
      chk("lit_mrst_fs", 32'(FRAME_START), 32'd1);
      repeat (35) step();
      @(negedge VID_CLK);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
